gaussian_input_feeder: RTL
==========================

# gaussian_input_feeder

Upstream stage of the `gaussian` accelerator. It accepts pixels from a ready/valid source, typically the DMA/global-buffer reader, and buffers them in a small FIFO. It serves them to `gaussian`'s `hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en` pull interface in raster order. It also tracks the row/column position within the frame, pulses at end of frame, and flags reads that arrive while the FIFO is empty.

## Interface
Parameters:
- `WIDTH`, 16: pixel width in bits.
- `DEPTH`, 8: FIFO entries; must be a power of 2, ≥ 2.
- `IMG_W`, 64: pixels per row.
- `IMG_H`, 64: rows per frame.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-high reset (asserted = 1), per codebase port naming.
- `flush`, in, 1: synchronous clear, same effect as reset.
- `in_valid`, in, 1: source word valid.
- `in_data`, in, WIDTH: source pixel.
- `in_ready`, out, 1: feeder can accept a word.
- `hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en`, in, 1: `gaussian` consumes one pixel this cycle.
- `hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read`, out, WIDTH: pixel presented to `gaussian`.
- `fill_level`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `col`, out, $clog2(IMG_W): column of the next pixel to be popped.
- `row`, out, $clog2(IMG_H): row of the next pixel to be popped.
- `frame_done`, out, 1: one-cycle pulse after the last pixel of a frame is popped.
- `underflow`, out, 1: sticky flag, set when a read occurs while the FIFO is empty.

## Operation
- **FIFO**
  - Circular buffer with write pointer, read pointer and count; no wrap-ambiguity (count disambiguates full from empty).
  - Push when `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`, derived combinationally from the count register.
  - Pop when `read_en`, the abbreviation used below for `hw_input_..._read_en`, is high and the FIFO is non-empty.
- **Read data**
  - When non-empty, `read` shows the head entry combinationally, so it is valid in the same cycle `read_en` is sampled.
  - When empty, `read` shows `last_q`, the most recently popped word (0 after reset or flush).
  - Every pop loads `last_q` with the head entry.
- **Simultaneous push and pop**
  - When non-empty and not full, count is unchanged and both pointers advance.
  - When full, no push occurs because `in_ready` is 0. The pop proceeds and `in_ready` rises the next cycle.
  - When empty with push and `read_en` together, there is no bypass. The push is stored (count becomes 1) and the read is an underflow.
- **Underflow**
  - `read_en` with count = 0 sets `underflow` (see Configuration).
  - `read` shows `last_q`, and the position counters still advance because the consumer used the slot.
- **Position counters**
  - Advance on every `read_en` cycle, whether or not the read underflowed.
  - `col` increments; at `IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At `row = IMG_H-1` and `col = IMG_W-1`, both counters wrap to 0 and `frame_done` is registered high for exactly one cycle.
- **Width rule:** data passes through unmodified; no arithmetic is applied to pixels.

## Timing
- Reset or flush values:
  - pointers, count, `fill_level`, `col`, `row`, `last_q`: 0
  - `frame_done`, `underflow`: 0
  - `in_ready`: 1
  - `read`: 0
- Latency is 1 cycle: a word pushed at edge N is visible on `read` and poppable from cycle N+1.
- `frame_done` is high in the cycle after the edge that consumed pixel (IMG_H-1, IMG_W-1).
- `flush` takes priority over a same-cycle push or pop. All contents are discarded and no `frame_done` pulse is produced.
- Reset asserted mid-frame clears all state immediately, asynchronously. The first pop after release is treated as pixel (0,0).

## Configuration
- Macro `GAUSSIAN_FEEDER_UNDERFLOW_CHECK_EN`.
- **Defined:**
  - `underflow` is a sticky register, cleared only by reset or flush.
  - A simulation-only assertion reports `$error` on every underflowing read.
- **Undefined:**
  - `underflow` is tied to 0 and the assertion is omitted.
  - All other behaviour, including counter advance and `last_q` output, is unchanged.

## Test plan
1. **Reset:** hold `rst_n` = 1 for 2 cycles, then release → `in_ready` = 1, `fill_level` = 0, `read` = 0, `col` = `row` = 0, `underflow` = 0.
2. **Fill, no read:** push 0x0001…0x0008 with `read_en` = 0 (DEPTH = 8) → `fill_level` = 8, `in_ready` = 0. A 9th `in_valid` is not accepted; `read` = 0x0001.
3. **Full, simultaneous pop:** with the FIFO full, assert `read_en` and `in_valid` for one cycle → 0x0001 consumed, no push that cycle, `in_ready` = 1 next cycle, `fill_level` = 7.
4. **Frame wrap:** IMG_W = 4, IMG_H = 2, stream 8 pixels with continuous `read_en` → pixels emerge in order. `col`/`row` step through (0,0)…(3,1), then wrap to (0,0). `frame_done` is high for exactly 1 cycle after the 8th pop.
5. **Underflow:** with the FIFO empty after popping 0x00AB, assert `read_en` → `read` = 0x00AB, `col` advances, `underflow` = 1 and stays 1 until flush (macro defined). With the macro undefined, `underflow` stays 0.
6. **Flush mid-frame:** with 3 words queued at `col` = 2, pulse `flush` together with `read_en` → `fill_level` = 0, `col` = 0, `read` = 0, no `frame_done`.

Source files
------------

// File: rtl/gaussian_input_feeder.sv
// Pixel FIFO feeding the gaussian pull interface, with raster position tracking.
// Optional macro GAUSSIAN_FEEDER_UNDERFLOW_CHECK_EN enables the sticky underflow flag and its assertion.
module gaussian_input_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  output logic [WIDTH-1:0]           hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic                       frame_done,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last_q;
  logic             read_en, empty, push, pop;

  // rst_n is active-high despite its name
  assign read_en  = hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en;
  assign empty    = (count == '0);
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = read_en && !empty;

  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read = empty ? last_q : mem[rd_ptr];
  assign fill_level = count;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_q     <= '0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_q     <= '0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // the consumer used the slot even on an underflow, so position always advances
      if (read_en) begin
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          if (row == RW'(IMG_H-1)) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef GAUSSIAN_FEEDER_UNDERFLOW_CHECK_EN
  logic underflow_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                     underflow_q <= 1'b0;
    else if (flush)                underflow_q <= 1'b0;
    else if (read_en && empty)     underflow_q <= 1'b1;
  end

  assign underflow = underflow_q;

`ifndef SYNTHESIS
  underflow_read: assert property (@(posedge clk) disable iff (rst_n || flush) !(read_en && empty))
    else $error("gaussian_input_feeder: read while FIFO empty");
`endif
`else
  assign underflow = 1'b0;
`endif

endmodule
